btn_confirm_sync: RTL and testbench

- Parametrised multi-channel conditioner for push-button and switch inputs feeding the CPU control path (ConfirmCtrl, start_pg, test_index switches).
- Per channel: 2-flop synchroniser, counter-based debounce filter, registered press/release single-cycle pulses.
- Generalises a single confirm-button path to CH channels.
- Sits between board pins and the CPU/IO controller; the CPU consumes `press_pulse` as its one-shot confirm strobe.

---
 rtl/btn_pkg.sv | 13 +
 rtl/btn_chan.sv | 81 ++++++++
 rtl/btn_confirm_sync.sv | 49 ++++
 tb/tb_btn_confirm_sync.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared timing constants for the button conditioner
package btn_pkg;

    localparam int DEBOUNCE_2MS_100MHZ = 200000;
    localparam int REPEAT_DELAY_DEF    = 50000000;
    localparam int REPEAT_PERIOD_DEF   = 10000000;

    // Short values so simulations reach acceptance and repeat in a few cycles
    localparam int DEBOUNCE_SIM        = 4;
    localparam int REPEAT_DELAY_SIM    = 10;
    localparam int REPEAT_PERIOD_SIM   = 3;

endpackage

// File: rtl/btn_chan.sv
// rtl/btn_chan.sv - one channel: 2-flop sync, counter debounce, press/release pulses
// Auto-repeat logic exists only when BTN_AUTOREPEAT_EN is defined.
module btn_chan
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_2MS_100MHZ,
    parameter int CNT_W           = 18,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic press_next
);

    if (DEBOUNCE_CYCLES < 1 || (2 ** CNT_W) <= DEBOUNCE_CYCLES ||
        REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
        $error("btn_chan: invalid timing parameters");
    end

    logic             sync0;
    logic             sync1;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             rpt_hit;

    assign accept     = (sync1 != stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign press_next = (accept && sync1) || rpt_hit;
    assign level      = stable;

`ifdef BTN_AUTOREPEAT_EN
    logic [31:0] rpt_cnt;

    // A release acceptance wins over a due repeat so press and release never overlap
    assign rpt_hit = stable && !accept && (rpt_cnt == 32'(REPEAT_DELAY - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt <= '0;
        end else if (!stable) begin
            rpt_cnt <= '0;
        end else if (rpt_hit) begin
            rpt_cnt <= 32'(REPEAT_DELAY - REPEAT_PERIOD);
        end else begin
            rpt_cnt <= rpt_cnt + 32'd1;
        end
    end
`else
    assign rpt_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0         <= 1'b0;
            sync1         <= 1'b0;
            stable        <= 1'b0;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync0         <= btn;
            sync1         <= sync0;
            press_pulse   <= press_next;
            release_pulse <= accept && !sync1;
            if (sync1 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_confirm_sync.sv
// rtl/btn_confirm_sync.sv - CH-channel button conditioner with registered any_press
// Optional auto-repeat on press_pulse is enabled by defining BTN_AUTOREPEAT_EN.
module btn_confirm_sync
    import btn_pkg::*;
#(
    parameter int CH              = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_2MS_100MHZ,
    parameter int CNT_W           = 18,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] btn_in,
    output logic [CH-1:0] level,
    output logic [CH-1:0] press_pulse,
    output logic [CH-1:0] release_pulse,
    output logic          any_press
);

    logic [CH-1:0] press_next;

    for (genvar i = 0; i < CH; i++) begin : g_chan
        btn_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .btn          (btn_in[i]),
            .level        (level[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .press_next   (press_next[i])
        );
    end

    // Registered from the pulse D-inputs so it lines up with press_pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_next;
        end
    end

endmodule

// File: tb/tb_btn_confirm_sync.sv
// tb/tb_btn_confirm_sync.sv - self-checking bench for btn_confirm_sync (CH=2, DEBOUNCE=4)
module tb_btn_confirm_sync;
    import btn_pkg::*;

    localparam int D  = DEBOUNCE_SIM;
    localparam int RD = REPEAT_DELAY_SIM;
    localparam int RP = REPEAT_PERIOD_SIM;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_in;
    logic [1:0] level, press_pulse, release_pulse;
    logic       any_press;

    int errors = 0;
    int checks = 0;

    btn_confirm_sync #(
        .CH(2), .DEBOUNCE_CYCLES(D), .CNT_W(3), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .level(level),
        .press_pulse(press_pulse), .release_pulse(release_pulse), .any_press(any_press)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a change is accepted once the last D synchronised samples all differ from the level
    bit hq[2][$];
    bit m_stable[2];
    bit m_press[2];
    bit m_rel[2];
    int held[2];

    always @(posedge clk or posedge rst) begin
        bit acc;
        bit samp;
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                hq[c] = {1'b0, 1'b0};
                m_stable[c] = 1'b0;
                m_press[c] = 1'b0;
                m_rel[c] = 1'b0;
                held[c] = 0;
            end else begin
                hq[c].push_back(btn_in[c]);
                samp = hq[c][hq[c].size() - 3];
                acc = (hq[c].size() >= D + 2);
                for (int j = 0; j < D; j++)
                    if (acc && hq[c][hq[c].size() - 3 - j] == m_stable[c]) acc = 1'b0;
                m_press[c] = acc && samp;
                m_rel[c] = acc && !samp;
`ifdef BTN_AUTOREPEAT_EN
                if (m_stable[c]) begin
                    held[c]++;
                    if (!acc && held[c] >= RD && (held[c] - RD) % RP == 0) m_press[c] = 1'b1;
                end
`endif
                if (acc) begin
                    m_stable[c] = samp;
                    held[c] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("level", level, {m_stable[1], m_stable[0]});
        check("press_pulse", press_pulse, {m_press[1], m_press[0]});
        check("release_pulse", release_pulse, {m_rel[1], m_rel[0]});
        check("any_press", any_press, m_press[0] | m_press[1]);
        check("press_release_overlap", press_pulse & release_pulse, 0);
    end

    int ncyc = 0;
    int t0;
    int pcnt[2], rcnt[2], acnt, pfirst[2], rfirst[2];

    task automatic clear();
        for (int c = 0; c < 2; c++) begin
            pcnt[c] = 0; rcnt[c] = 0; pfirst[c] = -1; rfirst[c] = -1;
        end
        acnt = 0;
        t0 = ncyc;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            ncyc++;
            for (int c = 0; c < 2; c++) begin
                if (press_pulse[c]) begin
                    pcnt[c]++;
                    if (pfirst[c] < 0) pfirst[c] = ncyc;
                end
                if (release_pulse[c]) begin
                    rcnt[c]++;
                    if (rfirst[c] < 0) rfirst[c] = ncyc;
                end
            end
            if (any_press) acnt++;
        end
    endtask

    initial begin
        for (int c = 0; c < 2; c++) hq[c] = {1'b0, 1'b0};
        rst = 1'b1;
        btn_in = 2'b11;
        clear();
        step(3);
        check("reset_level", level, 0);
        check("reset_pulses", pcnt[0] + pcnt[1] + rcnt[0] + rcnt[1] + acnt, 0);

        rst = 1'b0;
        clear();
        step(8);
        check("rst_release_press0_at", pfirst[0] - t0, 6);
        check("rst_release_press1_at", pfirst[1] - t0, 6);
        check("rst_release_any_cnt", acnt, 1);
        check("rst_release_level", level, 2'b11);

        btn_in = 2'b00;
        clear();
        step(10);
        check("release_both_at", rfirst[0] - t0, 6);
        check("release_both_cnt", rcnt[0] + rcnt[1], 2);

        btn_in = 2'b01;
        clear();
        step(10);
        check("clean_press_at", pfirst[0] - t0, 6);
        check("clean_press_cnt", pcnt[0], 1);
        check("clean_press_other", pcnt[1], 0);
        check("clean_press_level", level, 2'b01);

        btn_in = 2'b00;
        clear();
        step(10);
        check("release_ch0_cnt", rcnt[0], 1);

        clear();
        btn_in[0] = 1'b1; step(2);
        btn_in[0] = 1'b0; step(2);
        btn_in[0] = 1'b1; step(2);
        btn_in[0] = 1'b0; step(2);
        btn_in[0] = 1'b1;
        check("bounce_no_early_press", pcnt[0], 0);
        t0 = ncyc;
        step(12);
        check("bounce_press_cnt", pcnt[0], 1);
        check("bounce_press_at", pfirst[0] - t0, 6);

        clear();
        btn_in[1] = 1'b1; step(3);
        btn_in[1] = 1'b0; step(12);
        check("glitch3_press", pcnt[1], 0);
        check("glitch3_release", rcnt[1], 0);
        check("glitch3_level", level[1], 0);

        clear();
        btn_in[1] = 1'b1; step(4);
        btn_in[1] = 1'b0; step(14);
        check("pulse4_press_at", pfirst[1] - t0, 6);
        check("pulse4_release_at", rfirst[1] - t0, 10);
        check("pulse4_cnt", pcnt[1] + rcnt[1], 2);

        check("midrst_level_before", level[0], 1);
        btn_in[0] = 1'b0;
        step(4);
        #2 rst = 1'b1;
        #1;
        check("midrst_level_immediate", level, 0);
        check("midrst_any_immediate", any_press, 0);
        step(2);
        rst = 1'b0;
        clear();
        step(12);
        check("midrst_no_pulse", pcnt[0] + rcnt[0], 0);
        check("midrst_level_after", level, 0);

        clear();
        btn_in[0] = 1'b1;
        step(30);
        check("hold_first_at", pfirst[0] - t0, 6);
`ifdef BTN_AUTOREPEAT_EN
        check("hold_press_cnt", pcnt[0], 6);
`else
        check("hold_press_cnt", pcnt[0], 1);
`endif
        btn_in[0] = 1'b0;
        step(4);
        clear();
        step(4);
        check("hold_release_cnt", rcnt[0], 1);
        clear();
        step(20);
        check("after_release_no_press", pcnt[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
